// File: rtl/glitch_cfg_pkg.sv
// Shared definitions for the glitch-config shift interface: frame width, field offsets,
// transmitter state encoding and a small elaboration helper.
package glitch_cfg_pkg;

  localparam int REGISTER_WIDTH_DEF = 129;

  // Frame layout as seen in the receiver register (MSB = first bit on the wire)
  localparam int POL_BIT   = 0;
  localparam int CNT_A_LSB = 1;
  localparam int CNT_A_MSB = 64;
  localparam int CNT_B_LSB = 65;
  localparam int CNT_B_MSB = 128;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARM      = 3'd1,
    LOW      = 3'd2,
    HIGH     = 3'd3,
    WAIT_RDY = 3'd4,
    DONE     = 3'd5
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; output resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/data_shiftout.sv
// Serial frame transmitter for the glitch-config shift-in receiver (MSB first, plus one trailer
// t_clk pulse). Optional ready timeout is built when SHIFTOUT_TIMEOUT_EN is defined.
module data_shiftout
  import glitch_cfg_pkg::*;
#(
  parameter int REGISTER_WIDTH = REGISTER_WIDTH_DEF,
  parameter int CLK_HALF       = 4,
  parameter int ARM_CYCLES     = 4
`ifdef SHIFTOUT_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [REGISTER_WIDTH-1:0] din,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic                      t_clk,
  output logic                      t_data,
  output logic                      enable,
  input  logic                      ready_in,
  output state_e                    state_dbg
);

  localparam int BCW = $clog2(REGISTER_WIDTH + 2);
  localparam int PHW = $clog2(max_int(CLK_HALF, ARM_CYCLES) + 1);
  localparam logic [BCW-1:0] LAST_RISE   = BCW'(REGISTER_WIDTH + 1);
  localparam logic [BCW-1:0] TRAILER_CNT = BCW'(REGISTER_WIDTH);
  localparam logic [PHW-1:0] ARM_LAST    = PHW'(ARM_CYCLES - 1);
  localparam logic [PHW-1:0] HALF_LAST   = PHW'(CLK_HALF - 1);

  state_e                    state_q, state_d;
  logic [REGISTER_WIDTH-1:0] shreg_q, shreg_d;
  logic [BCW-1:0]            bit_cnt_q, bit_cnt_d;
  logic [PHW-1:0]            phase_q, phase_d;
  logic                      busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                      t_clk_q, t_clk_d, t_data_q, t_data_d, enable_q, enable_d;
  logic                      ready_sync;

`ifdef SHIFTOUT_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT_CYCLES - 1);
  logic [TCW-1:0] tmo_q, tmo_d;
`endif

  sync_2ff u_ready_sync (
    .clk   (clk),
    .reset (reset),
    .d     (ready_in),
    .q     (ready_sync)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      phase_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      t_clk_q   <= 1'b0;
      t_data_q  <= 1'b0;
      enable_q  <= 1'b0;
`ifdef SHIFTOUT_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      phase_q   <= phase_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      t_clk_q   <= t_clk_d;
      t_data_q  <= t_data_d;
      enable_q  <= enable_d;
`ifdef SHIFTOUT_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

  // Next-state logic also computes every registered output, so outputs change on transitions
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    phase_d   = phase_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    t_clk_d   = t_clk_q;
    t_data_d  = t_data_q;
    enable_d  = enable_q;
`ifdef SHIFTOUT_TIMEOUT_EN
    tmo_d     = tmo_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          shreg_d   = din;
          bit_cnt_d = '0;
          phase_d   = '0;
          busy_d    = 1'b1;
          enable_d  = 1'b0;
          t_clk_d   = 1'b0;
          t_data_d  = 1'b0;
          state_d   = ARM;
        end
      end
      ARM: begin
        if (phase_q == ARM_LAST) begin
          phase_d  = '0;
          enable_d = 1'b1;
          t_data_d = shreg_q[REGISTER_WIDTH-1];
          state_d  = LOW;
        end else begin
          phase_d = phase_q + PHW'(1);
        end
      end
      LOW: begin
        if (phase_q == HALF_LAST) begin
          phase_d   = '0;
          t_clk_d   = 1'b1;
          shreg_d   = shreg_q << 1;
          bit_cnt_d = bit_cnt_q + BCW'(1);
          state_d   = HIGH;
        end else begin
          phase_d = phase_q + PHW'(1);
        end
      end
      HIGH: begin
        if (phase_q == HALF_LAST) begin
          phase_d = '0;
          t_clk_d = 1'b0;
          if (bit_cnt_q < LAST_RISE) begin
            // The low phase after the last data bit carries the trailer pulse with data 0
            t_data_d = (bit_cnt_q == TRAILER_CNT) ? 1'b0 : shreg_q[REGISTER_WIDTH-1];
            state_d  = LOW;
          end else begin
            t_data_d = 1'b0;
            state_d  = WAIT_RDY;
`ifdef SHIFTOUT_TIMEOUT_EN
            tmo_d    = '0;
`endif
          end
        end else begin
          phase_d = phase_q + PHW'(1);
        end
      end
      WAIT_RDY: begin
        if (ready_sync) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end
`ifdef SHIFTOUT_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          err_d    = 1'b1;
          busy_d   = 1'b0;
          enable_d = 1'b0;
          state_d  = IDLE;
        end else begin
          tmo_d = tmo_q + TCW'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign t_clk     = t_clk_q;
  assign t_data    = t_data_q;
  assign enable    = enable_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_data_shiftout.sv
// Bench for data_shiftout with a behavioural shift-in receiver model on t_clk/t_data/enable.
// Define SHIFTOUT_TIMEOUT_EN to also exercise the ready timeout.
module tb_data_shiftout;
  import glitch_cfg_pkg::*;

  localparam int W   = 129;
  localparam int CH  = 2;
  localparam int AC  = 4;
  localparam int TMO = 16;

  localparam logic [W-1:0] VEC_A = 129'h1_DEADBEEF_CAFEF00D_01234567_89ABCDEF;
  localparam logic [W-1:0] VEC_B = 129'h0_5A5A5A5A_0F0F0F0F_13579BDF_2468ACE0;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] din = '0;
  logic         busy, done, err, t_clk, t_data, enable, ready_in;
  state_e       state_dbg;
  logic         block_ready = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  data_shiftout #(
    .REGISTER_WIDTH (W),
    .CLK_HALF       (CH),
    .ARM_CYCLES     (AC)
`ifdef SHIFTOUT_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (TMO)
`endif
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .din       (din),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .t_clk     (t_clk),
    .t_data    (t_data),
    .enable    (enable),
    .ready_in  (ready_in),
    .state_dbg (state_dbg)
  );

  // Receiver model: shifts W bits, then raises ready on the next rising edge; enable low clears it
  logic [W-1:0] rx_reg = '0;
  int           rx_cnt = 0;
  logic         rx_ready = 1'b0;

  always @(posedge t_clk or negedge enable) begin
    if (!enable) begin
      rx_reg   <= '0;
      rx_cnt   <= 0;
      rx_ready <= 1'b0;
    end else if (rx_cnt < W) begin
      rx_reg <= {rx_reg[W-2:0], t_data};
      rx_cnt <= rx_cnt + 1;
    end else begin
      rx_ready <= 1'b1;
    end
  end

  assign ready_in = rx_ready & ~block_ready;

  int done_cnt = 0;
  int err_cnt  = 0;
  int rise_cnt = 0;

  always @(posedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (err === 1'b1)  err_cnt  <= err_cnt + 1;
  end

  always @(posedge t_clk) rise_cnt <= rise_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [W-1:0] d);
    din   = d;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_done_timeout: got no done pulse, required one within 2000 cycles", name);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_tests++;
    if (busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_tests++;
    if (done !== 1'b0)   begin n_fail++; $display("FAIL reset_done: got %b required 0", done); end
    n_tests++;
    if (err !== 1'b0)    begin n_fail++; $display("FAIL reset_err: got %b required 0", err); end
    n_tests++;
    if (t_clk !== 1'b0)  begin n_fail++; $display("FAIL reset_t_clk: got %b required 0", t_clk); end
    n_tests++;
    if (t_data !== 1'b0) begin n_fail++; $display("FAIL reset_t_data: got %b required 0", t_data); end
    n_tests++;
    if (enable !== 1'b0) begin n_fail++; $display("FAIL reset_enable: got %b required 0", enable); end
    reset = 1'b0;
    repeat (2) tick();
    n_tests++;
    if (enable !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got enable=%b busy=%b required 0/0", enable, busy);
    end
  endtask

  task automatic test_frame_and_timing();
    int en_edge, tc_edge, d0, r0;
    en_edge = 0;
    tc_edge = 0;
    d0 = done_cnt;
    r0 = rise_cnt;
    pulse_start(VEC_A);
    n_tests++;
    if (busy !== 1'b1 || enable !== 1'b0) begin
      n_fail++;
      $display("FAIL start_accept: got busy=%b enable=%b required 1/0", busy, enable);
    end
    for (int e = 2; e <= 10; e++) begin
      tick();
      if (enable === 1'b1 && en_edge == 0) en_edge = e;
      if (t_clk === 1'b1 && tc_edge == 0) tc_edge = e;
    end
    n_tests++;
    if (en_edge != 5) begin n_fail++; $display("FAIL enable_rise_cycle: got %0d required 5", en_edge); end
    n_tests++;
    if (tc_edge != 7) begin n_fail++; $display("FAIL first_t_clk_cycle: got %0d required 7", tc_edge); end
    wait_done("frame_a");
    n_tests++;
    if (busy !== 1'b0 || enable !== 1'b1 || t_clk !== 1'b0) begin
      n_fail++;
      $display("FAIL done_state_outputs: got busy=%b enable=%b t_clk=%b required 0/1/0", busy, enable, t_clk);
    end
    repeat (3) tick();
    n_tests++;
    if (rx_reg !== VEC_A) begin n_fail++; $display("FAIL frame_a_data: got %h required %h", rx_reg, VEC_A); end
    n_tests++;
    if (rx_reg[POL_BIT] !== 1'b1) begin n_fail++; $display("FAIL frame_a_polarity: got %b required 1", rx_reg[POL_BIT]); end
    n_tests++;
    if (rx_reg[CNT_A_MSB:CNT_A_LSB] !== 64'h8091A2B3C4D5E6F7) begin
      n_fail++;
      $display("FAIL frame_a_cnt_a: got %h required 8091a2b3c4d5e6f7", rx_reg[CNT_A_MSB:CNT_A_LSB]);
    end
    n_tests++;
    if (rx_reg[CNT_B_MSB:CNT_B_LSB] !== 64'hEF56DF77E57F7806) begin
      n_fail++;
      $display("FAIL frame_a_cnt_b: got %h required ef56df77e57f7806", rx_reg[CNT_B_MSB:CNT_B_LSB]);
    end
    n_tests++;
    if (rise_cnt - r0 != W + 1) begin n_fail++; $display("FAIL frame_a_rises: got %0d required %0d", rise_cnt - r0, W + 1); end
    n_tests++;
    if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL frame_a_done_pulses: got %0d required 1", done_cnt - d0); end
  endtask

  task automatic test_back_to_back();
    int n_low, r0, d0;
    logic [W-1:0] ones;
    ones = '1;
    r0 = rise_cnt;
    pulse_start(ones);
    wait_done("frame_ones");
    repeat (2) tick();
    n_tests++;
    if (rx_reg !== ones) begin n_fail++; $display("FAIL frame_ones_data: got %h required all ones", rx_reg); end
    n_tests++;
    if (rise_cnt - r0 != W + 1) begin n_fail++; $display("FAIL frame_ones_rises: got %0d required %0d", rise_cnt - r0, W + 1); end
    r0 = rise_cnt;
    d0 = done_cnt;
    pulse_start('0);
    n_low = 0;
    while (enable !== 1'b1 && n_low < 50) begin
      n_low++;
      tick();
    end
    n_tests++;
    if (n_low != AC) begin n_fail++; $display("FAIL rearm_enable_low: got %0d cycles required %0d", n_low, AC); end
    wait_done("frame_zero");
    repeat (2) tick();
    n_tests++;
    if (rx_reg !== '0 || rx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_zero_data: got %h ready=%b required 0 ready=1", rx_reg, rx_ready);
    end
    n_tests++;
    if (rise_cnt - r0 != W + 1 || done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL frame_zero_counts: got rises=%0d dones=%0d required %0d/1", rise_cnt - r0, done_cnt - d0, W + 1);
    end
  endtask

  task automatic test_start_while_busy();
    int d0, r0;
    d0 = done_cnt;
    r0 = rise_cnt;
    pulse_start(VEC_B);
    repeat (3) tick();
    pulse_start(VEC_A);
    repeat (40) tick();
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_hold: got %b required 1", busy); end
    pulse_start(VEC_A);
    repeat (200) tick();
    pulse_start(VEC_A);
    wait_done("frame_b");
    repeat (3) tick();
    n_tests++;
    if (rx_reg !== VEC_B) begin n_fail++; $display("FAIL busy_ignore_data: got %h required %h", rx_reg, VEC_B); end
    n_tests++;
    if (done_cnt - d0 != 1 || rise_cnt - r0 != W + 1) begin
      n_fail++;
      $display("FAIL busy_ignore_counts: got dones=%0d rises=%0d required 1/%0d", done_cnt - d0, rise_cnt - r0, W + 1);
    end
  endtask

  task automatic test_reset_mid_frame();
    int r0;
    bit reached;
    r0 = rise_cnt;
    reached = 1'b0;
    pulse_start(VEC_A);
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (rise_cnt - r0 >= 60) begin
        reached = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!reached) begin n_fail++; $display("FAIL mid_frame_reach: got %0d rises required 60", rise_cnt - r0); end
    reset = 1'b1;
    #1;
    n_tests++;
    if ({busy, done, err, t_clk, t_data, enable} !== 6'b0) begin
      n_fail++;
      $display("FAIL mid_reset_async: got %b required 000000", {busy, done, err, t_clk, t_data, enable});
    end
    tick();
    n_tests++;
    if ({busy, done, err, t_clk, t_data, enable} !== 6'b0) begin
      n_fail++;
      $display("FAIL mid_reset_next_cycle: got %b required 000000", {busy, done, err, t_clk, t_data, enable});
    end
    reset = 1'b0;
    repeat (2) tick();
    r0 = rise_cnt;
    pulse_start(VEC_B);
    wait_done("after_reset");
    repeat (2) tick();
    n_tests++;
    if (rx_reg !== VEC_B || rise_cnt - r0 != W + 1) begin
      n_fail++;
      $display("FAIL after_reset_frame: got %h rises=%0d required %h rises=%0d", rx_reg, rise_cnt - r0, VEC_B, W + 1);
    end
  endtask

`ifdef SHIFTOUT_TIMEOUT_EN
  task automatic test_timeout();
    int n, e0, d0;
    bit in_wait;
    block_ready = 1'b1;
    e0 = err_cnt;
    d0 = done_cnt;
    in_wait = 1'b0;
    pulse_start(VEC_A);
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (state_dbg == WAIT_RDY) begin
        in_wait = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!in_wait) begin n_fail++; $display("FAIL timeout_reach_wait: got no WAIT_RDY required one"); end
    n = 0;
    while (err !== 1'b1 && n < 100) begin
      n++;
      tick();
    end
    n_tests++;
    if (n != TMO) begin n_fail++; $display("FAIL timeout_cycles: got %0d required %0d", n, TMO); end
    n_tests++;
    if (enable !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_outputs: got enable=%b busy=%b required 0/0", enable, busy);
    end
    repeat (3) tick();
    n_tests++;
    if (err_cnt - e0 != 1 || done_cnt - d0 != 0) begin
      n_fail++;
      $display("FAIL timeout_pulses: got errs=%0d dones=%0d required 1/0", err_cnt - e0, done_cnt - d0);
    end
    block_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_frame_and_timing();
    test_back_to_back();
    test_start_while_busy();
    test_reset_mid_frame();
`ifdef SHIFTOUT_TIMEOUT_EN
    test_timeout();
`endif
    n_tests++;
    if (err_cnt != 0 && err_cnt != 1) begin
      n_fail++;
      $display("FAIL err_total: got %0d required at most 1", err_cnt);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
